// File: rtl/vswitch_input_demux.sv
// Packet demultiplexer that steers whole AXI-Stream packets to one of five virtual-switch
// streams by the VID in tuser. Optional per-switch forward counters: VSWITCH_DEMUX_STATS_EN.
module vswitch_input_demux #(
    parameter int NUM_SWITCHES         = 5,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 304,
    parameter int C_S_AXIS_TUSER_WIDTH = 304,
    parameter int VID_LSB              = 32,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                              axis_aclk,
    input  logic                              axis_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_0_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_0_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_0_tuser,
    output logic                              m_axis_0_tvalid,
    input  logic                              m_axis_0_tready,
    output logic                              m_axis_0_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_1_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_1_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_1_tuser,
    output logic                              m_axis_1_tvalid,
    input  logic                              m_axis_1_tready,
    output logic                              m_axis_1_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_2_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_2_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_2_tuser,
    output logic                              m_axis_2_tvalid,
    input  logic                              m_axis_2_tready,
    output logic                              m_axis_2_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_3_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_3_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_3_tuser,
    output logic                              m_axis_3_tvalid,
    input  logic                              m_axis_3_tready,
    output logic                              m_axis_3_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_4_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_4_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_4_tuser,
    output logic                              m_axis_4_tvalid,
    input  logic                              m_axis_4_tready,
    output logic                              m_axis_4_tlast,

    output logic [CNT_WIDTH-1:0]              drop_cnt,
    output logic                              pkt_in
`ifdef VSWITCH_DEMUX_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]              fwd_cnt_0,
    output logic [CNT_WIDTH-1:0]              fwd_cnt_1,
    output logic [CNT_WIDTH-1:0]              fwd_cnt_2,
    output logic [CNT_WIDTH-1:0]              fwd_cnt_3,
    output logic [CNT_WIDTH-1:0]              fwd_cnt_4
`endif
);

    localparam int             KW     = C_M_AXIS_DATA_WIDTH / 8;
    localparam logic [3:0]     LP_NSW = 4'(NUM_SWITCHES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_DROP
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;

    logic                            r_out_valid;
    logic [2:0]                      r_out_sel;
    logic [2:0]                      r_dest;
    logic [C_M_AXIS_DATA_WIDTH-1:0]  r_tdata;
    logic [KW-1:0]                   r_tkeep;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] r_tuser;
    logic                            r_tlast;
    logic [CNT_WIDTH-1:0]            r_drop_cnt;
    logic                            r_pkt_in;

    logic [2:0]                      w_vid;
    logic                            w_vid_ok;
    logic [7:0]                      w_tready_vec;
    logic [4:0]                      w_tvalid_vec;
    logic                            w_sel_ready;
    logic                            w_acc;
    logic                            w_fwd_beat;
    logic                            w_drop_sop;
    logic                            w_sop_acc;
    logic [2:0]                      w_dest;

    assign w_vid        = s_axis_tuser[VID_LSB +: 3];
    assign w_vid_ok     = ({1'b0, w_vid} < LP_NSW);
    assign w_tready_vec = {3'b000, m_axis_4_tready, m_axis_3_tready, m_axis_2_tready,
                           m_axis_1_tready, m_axis_0_tready};
    // sel_ready looks at the pending beat's switch, which also enforces head-of-line ordering.
    assign w_sel_ready  = w_tready_vec[r_out_sel];
    assign s_axis_tready = (r_state == ST_DROP) || !r_out_valid || w_sel_ready;
    assign w_acc        = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fwd_beat  = 1'b0;
        w_drop_sop  = 1'b0;
        w_sop_acc   = 1'b0;
        w_dest      = r_dest;
        case (r_state)
            ST_IDLE: begin
                w_dest = w_vid;
                if (w_acc) begin
                    w_sop_acc = 1'b1;
                    if (w_vid_ok) begin
                        w_fwd_beat = 1'b1;
                        if (!s_axis_tlast) w_state_nxt = ST_FWD;
                    end else begin
                        w_drop_sop = 1'b1;
                        if (!s_axis_tlast) w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_FWD: begin
                if (w_acc) begin
                    w_fwd_beat = 1'b1;
                    if (s_axis_tlast) w_state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (w_acc && s_axis_tlast) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_out_valid <= 1'b0;
            r_out_sel   <= 3'd0;
            r_dest      <= 3'd0;
            r_drop_cnt  <= '0;
            r_pkt_in    <= 1'b0;
        end else begin
            r_pkt_in <= w_sop_acc;
            if (w_fwd_beat) begin
                r_out_valid <= 1'b1;
                r_out_sel   <= w_dest;
                r_dest      <= w_dest;
            end else if (w_sel_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_drop_sop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Payload needs no reset: it is only observed while r_out_valid is set.
    always_ff @(posedge axis_aclk) begin
        if (w_fwd_beat) begin
            r_tdata <= s_axis_tdata;
            r_tkeep <= s_axis_tkeep;
            r_tuser <= s_axis_tuser;
            r_tlast <= s_axis_tlast;
        end
    end

    for (genvar k = 0; k < 5; k++) begin : g_valid
        assign w_tvalid_vec[k] = r_out_valid && (r_out_sel == 3'(k)) && (k < NUM_SWITCHES);
    end

    assign m_axis_0_tvalid = w_tvalid_vec[0];
    assign m_axis_1_tvalid = w_tvalid_vec[1];
    assign m_axis_2_tvalid = w_tvalid_vec[2];
    assign m_axis_3_tvalid = w_tvalid_vec[3];
    assign m_axis_4_tvalid = w_tvalid_vec[4];

    assign m_axis_0_tdata = r_tdata;
    assign m_axis_1_tdata = r_tdata;
    assign m_axis_2_tdata = r_tdata;
    assign m_axis_3_tdata = r_tdata;
    assign m_axis_4_tdata = r_tdata;

    assign m_axis_0_tkeep = r_tkeep;
    assign m_axis_1_tkeep = r_tkeep;
    assign m_axis_2_tkeep = r_tkeep;
    assign m_axis_3_tkeep = r_tkeep;
    assign m_axis_4_tkeep = r_tkeep;

    assign m_axis_0_tuser = r_tuser;
    assign m_axis_1_tuser = r_tuser;
    assign m_axis_2_tuser = r_tuser;
    assign m_axis_3_tuser = r_tuser;
    assign m_axis_4_tuser = r_tuser;

    assign m_axis_0_tlast = r_tlast;
    assign m_axis_1_tlast = r_tlast;
    assign m_axis_2_tlast = r_tlast;
    assign m_axis_3_tlast = r_tlast;
    assign m_axis_4_tlast = r_tlast;

    assign drop_cnt = r_drop_cnt;
    assign pkt_in   = r_pkt_in;

`ifdef VSWITCH_DEMUX_STATS_EN
    logic [CNT_WIDTH-1:0] r_fwd_cnt [5];

    // A packet counts as forwarded once its last beat leaves on that switch's stream.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            for (int k = 0; k < 5; k++) r_fwd_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (w_tvalid_vec[k] && w_tready_vec[k] && r_tlast && (r_fwd_cnt[k] != '1)) begin
                    r_fwd_cnt[k] <= r_fwd_cnt[k] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign fwd_cnt_0 = r_fwd_cnt[0];
    assign fwd_cnt_1 = r_fwd_cnt[1];
    assign fwd_cnt_2 = r_fwd_cnt[2];
    assign fwd_cnt_3 = r_fwd_cnt[3];
    assign fwd_cnt_4 = r_fwd_cnt[4];
`else
    // Statistics disabled: no per-switch forward counters are built.
`endif

endmodule
